// File: rtl/square_iter.sv
// square_iter: iterative 32x32 unsigned squarer, radix-4 shift-add, 16 cycles; SQUARE_ROUND_EN rounds q half up
module square_iter (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic        start,
  output logic [63:0] p,
  output logic [31:0] q,
  output logic        busy,
  output logic        ready,
  output logic [3:0]  count
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [31:0] mcand, mplier;
  logic [33:0] acc, pp, sum;
  logic [63:0] prod;
  logic last;
  assign busy = state == RUN;
  assign last = count == 4'd15;
  // one radix-4 step: add m*a to the upper accumulator; prod is the shifted {acc, mplier} pair
  always_comb begin
    pp = ({2'b0, mcand} & {34{mplier[0]}}) + ({1'b0, mcand, 1'b0} & {34{mplier[1]}});
    sum = acc + pp;
    prod = {sum, mplier[31:2]};
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  // state register
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= IDLE;
    else state <= state_nxt;
  // datapath: load operand on accepted start, iterate while running, publish result on the last step
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      count <= '0;
      p <= '0;
      q <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (state == IDLE && start) begin
        mcand <= a;
        mplier <= a;
        acc <= '0;
        count <= '0;
      end else if (state == RUN) begin
        acc <= {2'b0, sum[33:2]};
        mplier <= {sum[1:0], mplier[31:2]};
        count <= count + 4'd1;
        if (last) begin
          p <= prod;
`ifdef SQUARE_ROUND_EN
          q <= prod[63:32] + {31'b0, prod[31]};
`else
          q <= prod[63:32];
`endif
          ready <= 1'b1;
        end
      end
    end
endmodule

// File: doc/square_iter.md
Name: square_iter

Overview:
- Iterative unsigned squarer; the inverse operation of the Newton square-root unit.
- Computes p = a*a for a 32-bit operand in 16 cycles, retiring 2 multiplier bits per cycle (radix-4 shift-add).
- Uses the same start/busy/ready/count handshake as the root unit, so a bench or datapath can chain sqrt -> square for round-trip checks.
- Sits beside the root/divide iterative units in the arithmetic library.

Parameters:
- none (operand width is fixed at 32, product at 64, iterations at 16)

Ports:
- clk    input   1   clock; all state updates on rising edge
- clrn   input   1   asynchronous active-low reset
- a      input   32  unsigned operand; sampled only on the accepted start edge
- start  input   1   request; accepted on a rising edge when busy=0
- p      output  64  full product a*a; holds the last result until the next completion
- q      output  32  upper-half result (see Optional Feature)
- busy   output  1   high while iterating
- ready  output  1   one-cycle completion pulse
- count  output  4   iteration index 0..15 while busy

Behaviour:
- Reset (clrn=0, asynchronous): p=0, busy=0, ready=0, count=0, internal accumulator/operand registers cleared. This applies at any time, including mid-operation: the operation is abandoned, no ready pulse is issued, and p stays 0.
- States:
  - IDLE (busy=0) -> RUN when start=1 at an edge E0. At E0: latch a into the multiplicand and multiplier registers, clear the accumulator, set count=0, set busy=1.
  - RUN, edges E1..E16:
    - Take the 2 LSBs m of the multiplier.
    - Add m*a (34-bit partial, m in 0..3) into the upper accumulator.
    - Shift {acc, multiplier} right by 2.
    - Increment count (wrapping 15->0 at E16).
  - At E16: p is loaded with the final 64-bit product, ready=1, busy=0, and the state returns to IDLE.
  - At E17: ready=0 unless a new completion occurs.
- Latency: the result is valid 16 edges after the accepted start. Back-to-back operation is allowed: a start sampled at E16 is ignored because busy was still high at that edge. A start at E17 is accepted, giving a 17-cycle minimum issue interval.
- start is ignored while busy=1. Changes on a are ignored after E0.
- Holding start high in IDLE re-launches the operation on every completion cycle after busy falls.
- The accumulator is 34 bits wide to absorb the 3*a partial product without loss.
- The final product is exact. There is no overflow, since max(p) = 0xFFFFFFFE00000001.
- p, q, and count are registered outputs. ready and busy are registered.

Optional Feature:
- Macro: SQUARE_ROUND_EN
- Defined: q = p[63:32] + p[31] (round half up), registered together with p at E16. The carry cannot overflow because p[63:32] <= 0xFFFFFFFE.
- Undefined: q = p[63:32] (truncated). No extra adder is built.

Test Plan:
- Reset held 35ns, then a=0x40000000 with start for one cycle -> busy for 16 cycles, count steps 0..15, ready pulse; p=0x1000000000000000, q=0x10000000 in both builds.
- a=0xC0000000 -> p=0x9000000000000000, q=0x90000000.
- a=0xFFFE0001 -> p=0xFFFC0005FFFC0001; q=0xFFFC0005 without the macro, 0xFFFC0006 with SQUARE_ROUND_EN.
- a=0xFFFFFFFF, then a=0 back-to-back with start held high -> p=0xFFFFFFFE00000001 (q=0xFFFFFFFE in both builds), then p=0 after the next 17-cycle interval. Check exactly one ready pulse per operation.
- start pulsed again at count=5 with a different a -> ignored; the result matches the original operand, and busy does not extend.
- clrn driven low at count=8 -> busy/ready/count/p go to 0 immediately (asynchronously), no ready pulse follows. A new start after release completes normally.
